wksg_arb: RTL and testbench

Two-requester arbiter that shares the single `wksg` signal channel between an X source and a Y source. It grants the `sx`/`sy` lines one at a time with round-robin fairness, a bounded hold time, optional early release and a guard gap between grants. It sits directly upstream of the signal unit and drives its select lines.

---
 rtl/wksg_arb.sv | 168 ++++++++++++++++
 tb/tb_wksg_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wksg_arb.sv
// Two-requester round-robin arbiter for the shared wksg signal channel.
// Grants sx/sy one at a time with a bounded hold, optional early release and a guard gap.
module wksg_arb #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic x_req,
    input  logic y_req,
    input  logic x_done,
    input  logic y_done,
    output logic sx,
    output logic sy,
    output logic x_ack,
    output logic y_ack,
    output logic last,
    output logic busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_X = 2'd1,
        S_GRANT_Y = 2'd2,
        S_GUARD   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic r_sx;
    logic r_sy;
    logic r_x_ack;
    logic r_y_ack;
    logic r_last;
    logic r_busy;

    logic w_sx_nxt;
    logic w_sy_nxt;
    logic w_x_ack_nxt;
    logic w_y_ack_nxt;
    logic w_last_nxt;
    logic w_busy_nxt;

    logic w_cnt_zero;
    logic w_arb_x;
    logic w_arb_y;

    // Tie goes to the requester not named by r_last.
    assign w_cnt_zero = (r_cnt == '0);
    assign w_arb_x    = x_req & (~y_req | r_last);
    assign w_arb_y    = y_req & (~x_req | ~r_last);

    // State and counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_arb_x) begin
                    w_state_nxt = S_GRANT_X;
                    w_cnt_nxt   = HOLD_LD;
                end else if (w_arb_y) begin
                    w_state_nxt = S_GRANT_Y;
                    w_cnt_nxt   = HOLD_LD;
                end
            end
            S_GRANT_X: begin
                if (x_done || w_cnt_zero) begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_GRANT_Y: begin
                if (y_done || w_cnt_zero) begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_GUARD: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_arb_x) begin
                    w_state_nxt = S_GRANT_X;
                    w_cnt_nxt   = HOLD_LD;
                end else if (w_arb_y) begin
                    w_state_nxt = S_GRANT_Y;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output next values follow the state being entered, so outputs align with it.
    always_comb begin
        w_sx_nxt    = 1'b0;
        w_sy_nxt    = 1'b0;
        w_x_ack_nxt = 1'b0;
        w_y_ack_nxt = 1'b0;
        w_last_nxt  = r_last;
        w_busy_nxt  = 1'b0;
        if (w_state_nxt == S_GRANT_X) begin
            w_sx_nxt    = 1'b1;
            w_x_ack_nxt = (r_state != S_GRANT_X);
            w_last_nxt  = 1'b0;
        end
        if (w_state_nxt == S_GRANT_Y) begin
            w_sy_nxt    = 1'b1;
            w_y_ack_nxt = (r_state != S_GRANT_Y);
            w_last_nxt  = 1'b1;
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_x_ack <= 1'b0;
            r_y_ack <= 1'b0;
            r_last  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_sx    <= w_sx_nxt;
            r_sy    <= w_sy_nxt;
            r_x_ack <= w_x_ack_nxt;
            r_y_ack <= w_y_ack_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign sx    = r_sx;
    assign sy    = r_sy;
    assign x_ack = r_x_ack;
    assign y_ack = r_y_ack;
    assign last  = r_last;
    assign busy  = r_busy;

endmodule

// File: tb/tb_wksg_arb.sv
// Bench for wksg_arb: two instances (GAP=1 and GAP=3) on shared inputs, checked every cycle
// against an elapsed-time model of the grant rules plus hand-computed directed expectations.
module tb_wksg_arb;

    localparam int HOLD = 4;
    localparam int GAP0 = 1;
    localparam int GAP1 = 3;

    logic clk = 1'b0;
    logic rst, x_req, y_req, x_done, y_done;
    logic [1:0] sx, sy, x_ack, y_ack, last, busy;

    wksg_arb #(.HOLD(HOLD), .GAP(GAP0)) u_a (
        .clk(clk), .rst(rst), .x_req(x_req), .y_req(y_req), .x_done(x_done), .y_done(y_done),
        .sx(sx[0]), .sy(sy[0]), .x_ack(x_ack[0]), .y_ack(y_ack[0]), .last(last[0]), .busy(busy[0])
    );
    wksg_arb #(.HOLD(HOLD), .GAP(GAP1)) u_b (
        .clk(clk), .rst(rst), .x_req(x_req), .y_req(y_req), .x_done(x_done), .y_done(y_done),
        .sx(sx[1]), .sy(sy[1]), .x_ack(x_ack[1]), .y_ack(y_ack[1]), .last(last[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int d, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %b want %b", name, d, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Inputs as seen at each rising edge.
    logic s_valid = 1'b0;
    logic s_rst, s_x_req, s_y_req, s_x_done, s_y_done;
    always @(posedge clk) begin
        s_valid  <= 1'b1;
        s_rst    <= rst;
        s_x_req  <= x_req;
        s_y_req  <= y_req;
        s_x_done <= x_done;
        s_y_done <= y_done;
    end

    // Model: owner 0=none 1=X 2=Y; age = cycles the grant has been up; gap = low cycles so far.
    int   gp_tab[2]  = '{GAP0, GAP1};
    int   m_owner[2] = '{0, 0};
    int   m_age[2]   = '{0, 0};
    int   m_gap[2]   = '{GAP0 + 1, GAP1 + 1};
    logic m_last[2]  = '{1'b1, 1'b1};
    logic m_ack[2]   = '{1'b0, 1'b0};

    task automatic model_step(input int d);
        int  gp;
        logic rel;
        gp = gp_tab[d];
        m_ack[d] = 1'b0;
        if (s_rst) begin
            m_owner[d] = 0;
            m_gap[d]   = gp + 1;
            m_last[d]  = 1'b1;
        end else if (m_owner[d] != 0) begin
            rel = ((m_owner[d] == 1) ? s_x_done : s_y_done) || (m_age[d] >= HOLD);
            if (rel) begin
                m_owner[d] = 0;
                m_gap[d]   = 1;
            end else begin
                m_age[d] = m_age[d] + 1;
            end
        end else if (m_gap[d] < gp) begin
            m_gap[d] = m_gap[d] + 1;
        end else if (s_x_req && (!s_y_req || m_last[d])) begin
            m_owner[d] = 1; m_age[d] = 1; m_ack[d] = 1'b1; m_last[d] = 1'b0;
        end else if (s_y_req) begin
            m_owner[d] = 2; m_age[d] = 1; m_ack[d] = 1'b1; m_last[d] = 1'b1;
        end else begin
            m_gap[d] = gp + 1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (s_valid) begin
            for (int d = 0; d < 2; d++) begin
                model_step(d);
                chk("m_sx",    d, sx[d],    m_owner[d] == 1);
                chk("m_sy",    d, sy[d],    m_owner[d] == 2);
                chk("m_x_ack", d, x_ack[d], m_ack[d] && m_owner[d] == 1);
                chk("m_y_ack", d, y_ack[d], m_ack[d] && m_owner[d] == 2);
                chk("m_last",  d, last[d],  m_last[d]);
                chk("m_busy",  d, busy[d],  (m_owner[d] != 0) || (m_gap[d] <= gp_tab[d]));
                chk("excl",    d, sx[d] & sy[d], 1'b0);
            end
        end
    end

    int exp_rel[9] = '{1, 1, 0, 1, 1, 1, 1, 0, 1};
    // {x_req, y_req, x_done, y_done}
    logic [3:0] vec[16] = '{4'b1100, 4'b1100, 4'b1110, 4'b0100, 4'b0101, 4'b1001,
                            4'b0000, 4'b1000, 4'b1111, 4'b0110, 4'b0100, 4'b1100,
                            4'b1101, 4'b0010, 4'b0001, 4'b1000};
    int n_sx, n_ack, n_busy, n_busy_b;

    initial begin
        rst = 1'b1; x_req = 1'b1; y_req = 1'b1; x_done = 1'b0; y_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sx",    0, sx[0],    1'b0);
        chk("rst_sy",    0, sy[0],    1'b0);
        chk("rst_x_ack", 0, x_ack[0], 1'b0);
        chk("rst_y_ack", 0, y_ack[0], 1'b0);
        chk("rst_busy",  0, busy[0],  1'b0);
        chk("rst_last",  0, last[0],  1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sx",    0, sx[0],    1'b1);
        chk("post_rst_x_ack", 0, x_ack[0], 1'b1);
        x_req = 1'b0; y_req = 1'b0;
        repeat (12) @(negedge clk);

        // Single one-cycle request.
        x_req = 1'b1;
        @(negedge clk);
        x_req = 1'b0;
        chk("single_first_ack", 0, x_ack[0], 1'b1);
        n_sx = 0; n_ack = 0; n_busy = 0; n_busy_b = 0;
        for (int i = 0; i < 10; i++) begin
            n_sx     += int'(sx[0]);
            n_ack    += int'(x_ack[0]);
            n_busy   += int'(busy[0]);
            n_busy_b += int'(busy[1]);
            @(negedge clk);
        end
        chk_int("single_sx_cycles", n_sx, 4);
        chk_int("single_ack_cycles", n_ack, 1);
        chk_int("single_busy_cycles", n_busy, 5);
        chk_int("single_busy_cycles_gap3", n_busy_b, 7);
        chk("single_last", 0, last[0], 1'b0);

        // Contention after reset: X first, period HOLD+GAP.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; x_req = 1'b1; y_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("cont_sx", 0, sx[0], (i % 10) < 4);
            chk("cont_sy", 0, sy[0], (i % 10) >= 5 && (i % 10) < 9);
        end
        x_req = 1'b0; y_req = 1'b0;
        repeat (12) @(negedge clk);

        // Early release in the second sy cycle, then a full-length grant.
        y_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("rel_sy", 0, sy[0], exp_rel[i] == 1);
            if (i == 3) chk("rel_regrant_ack", 0, y_ack[0], 1'b1);
            y_done = 1'(i == 1);
        end
        y_req = 1'b0; y_done = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in the third sx cycle, then a fresh grant.
        x_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i <= 2) chk("rmid_sx_pre", 0, sx[0], 1'b1);
            if (i == 3) begin
                chk("rmid_sx",    0, sx[0],    1'b0);
                chk("rmid_x_ack", 0, x_ack[0], 1'b0);
                chk("rmid_last",  0, last[0],  1'b1);
            end
            if (i == 4) chk("rmid_new_ack", 0, x_ack[0], 1'b1);
            if (i >= 4 && i <= 7) chk("rmid_new_sx", 0, sx[0], 1'b1);
            if (i == 8) chk("rmid_end_sx", 0, sx[0], 1'b0);
            rst = 1'(i == 2);
        end
        x_req = 1'b0;
        repeat (12) @(negedge clk);

        // GAP=3: continuous X with y_done noise, then continuous Y with x_done noise.
        x_req = 1'b1; y_done = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("gap3_sx", 1, sx[1], (i % 7) < 4);
            if (i == 7) chk("gap3_x_ack", 1, x_ack[1], 1'b1);
        end
        x_req = 1'b0; y_done = 1'b0;
        repeat (12) @(negedge clk);
        y_req = 1'b1; x_done = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("gap3_sy", 1, sy[1], (i % 7) < 4);
        end
        y_req = 1'b0; x_done = 1'b0;
        repeat (12) @(negedge clk);

        // Mixed directed vectors, checked by the model only.
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < 16; v++) begin
                {x_req, y_req, x_done, y_done} = vec[v];
                @(negedge clk);
            end
        end
        {x_req, y_req, x_done, y_done} = 4'b0000;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
